// File: rtl/io_byte_responder.sv
// Avalon-MM IO responder that splits dword-aligned IO accesses into single-byte
// accesses on an 8-bit legacy device bus. Writes are posted; reads are reassembled.
module io_byte_responder #(
    parameter int ADDR_W     = 4,
    parameter int DEV_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic [3:0]        avs_byteenable,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [ADDR_W+1:0] dev_address,
    output logic              dev_read,
    output logic              dev_write,
    output logic [7:0]        dev_writedata,
    input  logic [7:0]        dev_readdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_BYTE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'(DEV_RD_LAT - 1);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_dword;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [3:0]        r_pend;
    logic [1:0]        r_lane;
    logic [1:0]        r_waitCnt;
    logic              r_devRead;
    logic              r_devWrite;
    logic [ADDR_W+1:0] r_devAddr;
    logic [7:0]        r_devWdata;
    logic              r_rdValid;
    logic [31:0]       r_readdata;

    logic              w_issueWr;
    logic              w_issueRd;
    logic              w_sample;
    logic [3:0]        w_srcMask;
    logic [1:0]        w_issueLane;
    logic [ADDR_W-1:0] w_dword;
    logic [31:0]       w_wdata;
    logic [31:0]       w_asmSampled;

    function automatic logic [1:0] lowLane(input logic [3:0] mask);
        if (mask[0]) return 2'd0;
        else if (mask[1]) return 2'd1;
        else if (mask[2]) return 2'd2;
        else return 2'd3;
    endfunction

    // w_srcMask is the set of lanes still to visit; the lowest one is strobed next.
    always_comb begin
        w_nextState = r_state;
        w_issueWr   = 1'b0;
        w_issueRd   = 1'b0;
        w_sample    = 1'b0;
        w_srcMask   = r_pend;
        case (r_state)
            IDLE: begin
                w_srcMask = avs_byteenable;
                if (avs_write) begin
                    w_nextState = WR_BYTE;
                    w_issueWr   = |avs_byteenable;
                end else if (avs_read) begin
                    w_nextState = (|avs_byteenable) ? RD_ISSUE : RD_RESP;
                    w_issueRd   = |avs_byteenable;
                end
            end
            WR_BYTE: begin
                w_issueWr = |r_pend;
                if (~|r_pend) w_nextState = IDLE;
            end
            RD_ISSUE: w_nextState = RD_WAIT;
            RD_WAIT: begin
                if (r_waitCnt == 2'd0) begin
                    w_sample    = 1'b1;
                    w_issueRd   = |r_pend;
                    w_nextState = (|r_pend) ? RD_ISSUE : RD_RESP;
                end
            end
            RD_RESP: w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    assign w_issueLane = lowLane(w_srcMask);
    assign w_dword     = (r_state == IDLE) ? avs_address : r_dword;
    assign w_wdata     = (r_state == IDLE) ? avs_writedata : r_wdata;

    always_comb begin
        w_asmSampled = r_asm;
        w_asmSampled[{r_lane, 3'b000} +: 8] = dev_readdata;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dword    <= '0;
            r_wdata    <= '0;
            r_asm      <= '1;
            r_pend     <= '0;
            r_lane     <= '0;
            r_waitCnt  <= '0;
            r_devRead  <= 1'b0;
            r_devWrite <= 1'b0;
            r_devAddr  <= '0;
            r_devWdata <= '0;
            r_rdValid  <= 1'b0;
            r_readdata <= '1;
        end else begin
            r_devRead  <= w_issueRd;
            r_devWrite <= w_issueWr;
            r_rdValid  <= (w_nextState == RD_RESP);

            if (r_state == IDLE && (avs_read || avs_write)) begin
                r_dword <= avs_address;
                r_wdata <= avs_writedata;
                r_asm   <= '1;
            end

            if (w_issueRd || w_issueWr) begin
                r_lane     <= w_issueLane;
                r_pend     <= w_srcMask & (w_srcMask - 4'd1);
                r_devAddr  <= {w_dword, w_issueLane};
                r_devWdata <= w_wdata[{w_issueLane, 3'b000} +: 8];
            end else if (r_state == IDLE) begin
                r_pend <= '0;
            end

            if (r_state == RD_ISSUE) r_waitCnt <= WAIT_INIT;
            else if (r_state == RD_WAIT && r_waitCnt != 2'd0) r_waitCnt <= r_waitCnt - 2'd1;

            if (w_sample) r_asm <= w_asmSampled;

            // Response data is captured on entry to RD_RESP and then held until the next read.
            if (w_nextState == RD_RESP)
                r_readdata <= (r_state == IDLE) ? 32'hFFFF_FFFF : w_asmSampled;
        end
    end

    assign avs_waitrequest   = rst || (r_state != IDLE);
    assign avs_readdata      = r_readdata;
    assign avs_readdatavalid = r_rdValid;
    assign dev_address       = r_devAddr;
    assign dev_read          = r_devRead;
    assign dev_write         = r_devWrite;
    assign dev_writedata     = r_devWdata;

endmodule

// File: tb/tb_io_byte_responder.sv
// Bench for io_byte_responder: two instances (read latency 1 and 3), a latency-accurate device model,
// and a transaction-level reference model that predicts every device strobe and read response.
module tb_io_byte_responder;
    localparam int ADDR_W = 4;
    localparam int LAT0   = 1;
    localparam int LAT1   = 3;

    typedef struct {
        int          inst;
        int          cyc;
        int          kind;
        int          addr;
        logic [31:0] data;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] avsAddress [2];
    logic [3:0]        avsBe      [2];
    logic              avsRead    [2];
    logic              avsWrite   [2];
    logic [31:0]       avsWdata   [2];
    logic              avsWaitreq [2];
    logic [31:0]       avsRdata   [2];
    logic              avsRdv     [2];
    logic [ADDR_W+1:0] devAddress [2];
    logic              devRead    [2];
    logic              devWrite   [2];
    logic [7:0]        devWdata   [2];
    logic [7:0]        devRdData  [2];

    logic [7:0]  devMem [2][64];
    int          dueCyc [2] = '{-1, -1};
    logic [7:0]  dueVal [2] = '{8'h00, 8'h00};
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    ev_t         evLog [$];
    ev_t         expQ [$];
    int          expIdle;
    logic [31:0] expRdata;

    io_byte_responder #(.ADDR_W(ADDR_W), .DEV_RD_LAT(LAT0)) dut0 (
        .clk(clk), .rst(rst),
        .avs_address(avsAddress[0]), .avs_byteenable(avsBe[0]),
        .avs_read(avsRead[0]), .avs_write(avsWrite[0]), .avs_writedata(avsWdata[0]),
        .avs_waitrequest(avsWaitreq[0]), .avs_readdata(avsRdata[0]), .avs_readdatavalid(avsRdv[0]),
        .dev_address(devAddress[0]), .dev_read(devRead[0]), .dev_write(devWrite[0]),
        .dev_writedata(devWdata[0]), .dev_readdata(devRdData[0])
    );

    io_byte_responder #(.ADDR_W(ADDR_W), .DEV_RD_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst),
        .avs_address(avsAddress[1]), .avs_byteenable(avsBe[1]),
        .avs_read(avsRead[1]), .avs_write(avsWrite[1]), .avs_writedata(avsWdata[1]),
        .avs_waitrequest(avsWaitreq[1]), .avs_readdata(avsRdata[1]), .avs_readdatavalid(avsRdv[1]),
        .dev_address(devAddress[1]), .dev_read(devRead[1]), .dev_write(devWrite[1]),
        .dev_writedata(devWdata[1]), .dev_readdata(devRdData[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latOf(input int g);
        return (g == 0) ? LAT0 : LAT1;
    endfunction

    // Device: read data is valid only in the cycle exactly LAT after the strobe, inverted junk otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (devWrite[g] === 1'b1)
                evLog.push_back('{g, cyc, 0, int'(devAddress[g]), {24'd0, devWdata[g]}});
            if (devRead[g] === 1'b1) begin
                evLog.push_back('{g, cyc, 1, int'(devAddress[g]), 32'd0});
                dueCyc[g] = cyc + latOf(g);
                dueVal[g] = devMem[g][devAddress[g]];
            end
            if (avsRdv[g] === 1'b1)
                evLog.push_back('{g, cyc, 2, 0, avsRdata[g]});
            devRdData[g] = (cyc == dueCyc[g]) ? dueVal[g] : ~dueVal[g];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Reference model: lanes visited in ascending order, each write lane one cycle,
    // each read lane (LAT+1) cycles, response one cycle after the last lane.
    task automatic modelTxn(input int sel, input logic rd, input logic wr, input logic [3:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, input int a);
        int lat = latOf(sel);
        int n = 0;
        expQ.delete();
        expRdata = 32'hFFFF_FFFF;
        if (wr) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    expQ.push_back('{sel, a + 1 + n, 0, int'(addr) * 4 + lane, {24'd0, wd[8*lane +: 8]}});
                    n++;
                end
            end
            expIdle = a + 1 + ((n == 0) ? 1 : n);
        end else if (rd) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (be[lane]) begin
                    expQ.push_back('{sel, a + 1 + n * (lat + 1), 1, int'(addr) * 4 + lane, 32'd0});
                    expRdata[8*lane +: 8] = devMem[sel][int'(addr) * 4 + lane];
                    n++;
                end
            end
            expQ.push_back('{sel, a + 1 + n * (lat + 1), 2, 0, expRdata});
            expIdle = a + 2 + n * (lat + 1);
        end
    endtask

    task automatic compareEvents(input int sel);
        ev_t act [$];
        foreach (evLog[i]) if (evLog[i].inst == sel) act.push_back(evLog[i]);
        checkOutput($sformatf("i%0d evCount", sel), act.size(), expQ.size());
        for (int i = 0; i < act.size() && i < expQ.size(); i++) begin
            checkOutput($sformatf("i%0d ev%0d kind", sel, i), act[i].kind, expQ[i].kind);
            checkOutput($sformatf("i%0d ev%0d cyc", sel, i), act[i].cyc - expQ[i].cyc, 0);
            checkOutput($sformatf("i%0d ev%0d addr", sel, i), act[i].addr, expQ[i].addr);
            checkOutput($sformatf("i%0d ev%0d data", sel, i), act[i].data, expQ[i].data);
        end
    endtask

    task automatic issueCmd(input int sel, input logic rd, input logic wr, input logic [3:0] addr,
                            input logic [3:0] be, input logic [31:0] wd, output int a);
        @(negedge clk);
        for (int n = 0; n < 100; n++) begin
            if (avsWaitreq[sel] === 1'b0) break;
            @(negedge clk);
        end
        checkOutput($sformatf("i%0d readyToAccept", sel), avsWaitreq[sel], 1'b0);
        evLog.delete();
        avsAddress[sel] = addr;
        avsBe[sel]      = be;
        avsWdata[sel]   = wd;
        avsRead[sel]    = rd;
        avsWrite[sel]   = wr;
        a = cyc;
        @(negedge clk);
        avsRead[sel]  = 1'b0;
        avsWrite[sel] = 1'b0;
    endtask

    task automatic applyStimulus(input int sel, input logic rd, input logic wr, input logic [3:0] addr,
                                 input logic [3:0] be, input logic [31:0] wd);
        int a;
        int idleCyc = -1;
        issueCmd(sel, rd, wr, addr, be, wd, a);
        modelTxn(sel, rd, wr, addr, be, wd, a);
        for (int n = 0; n < 60; n++) begin
            if (avsWaitreq[sel] === 1'b0) begin
                idleCyc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput($sformatf("i%0d idleCycle", sel), idleCyc - a, expIdle - a);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        compareEvents(sel);
        if (rd && !wr) checkOutput($sformatf("i%0d rdataHold", sel), avsRdata[sel], expRdata);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int a;
        for (int g = 0; g < 2; g++) begin
            avsAddress[g] = '0;
            avsBe[g]      = '0;
            avsRead[g]    = 1'b0;
            avsWrite[g]   = 1'b0;
            avsWdata[g]   = '0;
            for (int m = 0; m < 64; m++) devMem[g][m] = 8'($urandom);
        end
        devMem[0][1] = 8'hAB;
        devMem[0][2] = 8'hCD;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("i%0d rstWaitreq", s), avsWaitreq[s], 1'b1);
            checkOutput($sformatf("i%0d rstRdv", s), avsRdv[s], 1'b0);
            checkOutput($sformatf("i%0d rstRdata", s), avsRdata[s], 32'hFFFF_FFFF);
            checkOutput($sformatf("i%0d rstDevRd", s), devRead[s], 1'b0);
            checkOutput($sformatf("i%0d rstDevWr", s), devWrite[s], 1'b0);
            checkOutput($sformatf("i%0d rstDevAddr", s), devAddress[s], 0);
            checkOutput($sformatf("i%0d rstDevWdata", s), devWdata[s], 0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++)
            checkOutput($sformatf("i%0d idleAfterRst", s), avsWaitreq[s], 1'b0);

        $display("[TB] directed transactions");
        applyStimulus(0, 1'b0, 1'b1, 4'd3, 4'b1111, 32'h4433_2211);
        applyStimulus(0, 1'b1, 1'b0, 4'd0, 4'b0110, 32'h0);
        applyStimulus(0, 1'b1, 1'b0, 4'd5, 4'b0000, 32'h0);
        applyStimulus(0, 1'b0, 1'b1, 4'd6, 4'b0000, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 1'b1, 4'd2, 4'b0001, 32'h0000_0077);
        applyStimulus(1, 1'b1, 1'b0, 4'd9, 4'b1000, 32'h0);
        applyStimulus(1, 1'b0, 1'b1, 4'd15, 4'b0101, 32'hA1B2_C3D4);
        applyStimulus(1, 1'b1, 1'b0, 4'd7, 4'b1111, 32'h0);

        $display("[TB] reset during a four-lane read");
        issueCmd(0, 1'b1, 1'b0, 4'd4, 4'b1111, 32'h0, a);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("resetWaitreqHigh", avsWaitreq[0], 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetWaitreqLow", avsWaitreq[0], 1'b0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        expQ.delete();
        expQ.push_back('{0, a + 1, 1, 16, 32'd0});
        compareEvents(0);
        checkOutput("resetRdata", avsRdata[0], 32'hFFFF_FFFF);

        $display("[TB] randomized transactions");
        for (int i = 0; i < 40; i++) begin
            int op = $urandom_range(0, 4);
            int sel = $urandom_range(0, 1);
            logic rd = (op >= 2);
            logic wr = (op <= 1) || (op == 4);
            applyStimulus(sel, rd, wr, 4'($urandom), 4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
